// File: rtl/down_counter.sv
// Loadable down-counter sequencer: load N on start, decrement per enabled clock,
// pulse done for one cycle at terminal count, then return to idle.
module down_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: defaults first, so any path that does not assign a signal holds it
  // instead of inferring a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = load_value;
          state_d = (load_value == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort outranks both enable and the terminal-count transition.
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (enable) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign count = count_q;
  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_down_counter;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             enable = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [WIDTH-1:0] count;
  logic             ready, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: an operation is either inactive, counting with m_rem left, or
  // reporting completion for one cycle.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_rem    = 0;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_value (load_value),
    .enable     (enable),
    .abort      (abort),
    .count      (count),
    .ready      (ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_rem    = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_rem  = 0;
    end else if (!m_active) begin
      if (start) begin
        m_rem = int'(load_value);
        if (m_rem == 0) m_done = 1'b1;
        else m_active = 1'b1;
      end
    end else if (abort) begin
      m_active = 1'b0;
      m_rem    = 0;
    end else if (enable) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("count", int'(count), m_rem);
      check("ready", int'(ready), int'(!m_active && !m_done));
      check("busy",  int'(busy),  int'(m_active));
      check("done",  int'(done),  int'(m_done));
      check("onehot", int'(ready) + int'(busy) + int'(done), 1);
    end
  end

  // Counts negedges from the call until done is seen, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 64) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges;

    repeat (2) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_busy",  int'(busy),  0);
    check("rst_done",  int'(done),  0);
    reset = 1'b1;
    @(negedge clk);

    // Basic count N=5.
    start = 1'b1; load_value = 5; enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("basic_load", int'(count), 5);
    for (int i = 4; i >= 1; i--) begin
      @(negedge clk);
      check("basic_seq", int'(count), i);
    end
    @(negedge clk);
    check("basic_zero", int'(count), 0);
    check("basic_done", int'(done), 1);
    @(negedge clk);
    check("basic_ready", int'(ready), 1);
    check("basic_done_off", int'(done), 0);

    // Pause: N=4, enable low for three edges once count reaches 2.
    start = 1'b1; load_value = 4;
    @(negedge clk);
    start = 1'b0;
    check("pause_load", int'(count), 4);
    @(negedge clk);
    @(negedge clk);
    check("pause_at2", int'(count), 2);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("pause_hold", int'(count), 2);
      check("pause_busy", int'(busy), 1);
    end
    enable = 1'b1;
    wait_done(edges);
    check("pause_latency", edges + 5, 7);
    @(negedge clk);

    // N=0 goes straight to DONE.
    start = 1'b1; load_value = 0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    @(negedge clk);
    check("zero_ready", int'(ready), 1);

    // N=31 full range, no wrap.
    start = 1'b1; load_value = 31;
    @(negedge clk);
    start = 1'b0;
    check("max_load", int'(count), 31);
    wait_done(edges);
    check("max_latency", edges, 31);
    @(negedge clk);

    // Abort coincident with terminal count.
    start = 1'b1; load_value = 1; enable = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("abort_load", int'(count), 1);
    abort = 1'b1; enable = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", int'(ready), 1);
    check("abort_count", int'(count), 0);
    repeat (3) begin
      check("abort_nodone", int'(done), 0);
      @(negedge clk);
    end

    // Ignored start in RUN and in DONE.
    start = 1'b1; load_value = 6;
    @(negedge clk);
    check("ign_load", int'(count), 6);
    start = 1'b0;
    @(negedge clk);
    check("ign_seq", int'(count), 5);
    start = 1'b1; load_value = 9;
    @(negedge clk);
    start = 1'b0;
    check("ign_run", int'(count), 4);
    wait_done(edges);
    check("ign_latency", edges, 4);
    start = 1'b1; load_value = 9;
    @(negedge clk);
    start = 1'b0;
    check("ign_done_ready", int'(ready), 1);
    check("ign_done_count", int'(count), 0);
    @(negedge clk);
    check("ign_no_queue", int'(busy), 0);

    // Asynchronous reset mid-RUN at count=7, then immediate restart.
    start = 1'b1; load_value = 10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("areset_pre", int'(count), 7);
    #2 reset = 1'b0;
    #1;
    check("areset_count", int'(count), 0);
    check("areset_ready", int'(ready), 1);
    check("areset_busy",  int'(busy),  0);
    check("areset_done",  int'(done),  0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; load_value = 3;
    @(negedge clk);
    start = 1'b0;
    check("areset_restart", int'(count), 3);
    check("areset_rbusy", int'(busy), 1);
    wait_done(edges);
    check("areset_latency", edges, 3);
    @(negedge clk);

    // Randomized traffic, checked against the model every cycle.
    repeat (3000) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                               : WIDTH'($urandom_range(0, 6));
      enable     = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end

    start = 1'b0; enable = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
